// File: rtl/mpll_lock_detect.sv
// PLL lock detector: windowed PFD activity measurement with lock hysteresis,
// sticky lock-lost flag and frequency-error direction.
module mpll_lock_detect #(
  parameter int unsigned WINDOW_BITS = 16,
  parameter int unsigned LOCK_THR    = 655,
  parameter int unsigned UNLOCK_THR  = 3277,
  parameter int unsigned LOCK_COUNT  = 8
) (
  input  logic                   clock,
  input  logic                   reset_n,
  input  logic                   pol,
  input  logic                   enable,
  input  logic                   clear_lost,
  output logic                   locked,
  output logic                   lock_lost,
  output logic [WINDOW_BITS-1:0] active_cnt,
  output logic [1:0]             freq_dir,
  output logic                   window_done
);

  typedef logic [WINDOW_BITS-1:0] cnt_t;
  typedef enum logic [1:0] {
    UNLOCKED = 2'd0,
    ACQUIRE  = 2'd1,
    LOCKED   = 2'd2
  } state_e;

  localparam cnt_t ALL1 = '1;

  function automatic cnt_t sat_inc(cnt_t v, logic inc);
    return (inc && v != ALL1) ? v + cnt_t'(1) : v;
  endfunction

  logic   pol_m_q, pol_s_q, en_m_q, en_s_q;
  cnt_t   wcnt_q, wcnt_d;
  cnt_t   act_q, act_d, up_q, up_d, dn_q, dn_d;
  cnt_t   act_fin, up_fin, dn_fin;
  cnt_t   active_q, active_d;
  logic [1:0] dir_q, dir_d;
  logic   done_q, done_d;
  logic   locked_q, locked_d;
  logic   lost_q, lost_d;
  state_e state_q, state_d;
  logic [7:0] good_q, good_d, good_inc;
  logic   close, good_w, bad_w, lost_set;
  logic [31:0] act_ext;

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      pol_m_q  <= 1'b0;
      pol_s_q  <= 1'b0;
      en_m_q   <= 1'b0;
      en_s_q   <= 1'b0;
      wcnt_q   <= '0;
      act_q    <= '0;
      up_q     <= '0;
      dn_q     <= '0;
      active_q <= '0;
      dir_q    <= 2'b00;
      done_q   <= 1'b0;
      locked_q <= 1'b0;
      lost_q   <= 1'b0;
      state_q  <= UNLOCKED;
      good_q   <= '0;
    end else begin
      pol_m_q  <= pol;
      pol_s_q  <= pol_m_q;
      en_m_q   <= enable;
      en_s_q   <= en_m_q;
      wcnt_q   <= wcnt_d;
      act_q    <= act_d;
      up_q     <= up_d;
      dn_q     <= dn_d;
      active_q <= active_d;
      dir_q    <= dir_d;
      done_q   <= done_d;
      locked_q <= locked_d;
      lost_q   <= lost_d;
      state_q  <= state_d;
      good_q   <= good_d;
    end
  end

  // The closing cycle's own sample is folded into the final counts
  always_comb begin
    close    = (wcnt_q == ALL1);
    wcnt_d   = wcnt_q + cnt_t'(1);
    act_fin  = sat_inc(act_q, en_s_q);
    up_fin   = sat_inc(up_q, en_s_q & pol_s_q);
    dn_fin   = sat_inc(dn_q, en_s_q & ~pol_s_q);
    act_d    = close ? '0 : act_fin;
    up_d     = close ? '0 : up_fin;
    dn_d     = close ? '0 : dn_fin;
    active_d = active_q;
    dir_d    = dir_q;
    done_d   = close;
    if (close) begin
      active_d = act_fin;
      if (up_fin > dn_fin)      dir_d = 2'b01;
      else if (dn_fin > up_fin) dir_d = 2'b10;
      else                      dir_d = 2'b00;
    end
  end

  // A saturated count is treated as exceeding every threshold
  always_comb begin
    act_ext  = 32'(act_fin);
    good_w   = (act_fin != ALL1) && (act_ext <= LOCK_THR);
    bad_w    = (act_fin == ALL1) || (act_ext > UNLOCK_THR);
    good_inc = good_q + 8'd1;
    state_d  = state_q;
    good_d   = good_q;
    lost_set = 1'b0;
    if (close) begin
      unique case (state_q)
        UNLOCKED: begin
          if (good_w) begin
            good_d  = 8'd1;
            state_d = (LOCK_COUNT == 1) ? LOCKED : ACQUIRE;
          end else begin
            good_d = '0;
          end
        end
        ACQUIRE: begin
          if (good_w) begin
            good_d = good_inc;
            if (32'(good_inc) == LOCK_COUNT) state_d = LOCKED;
          end else begin
            good_d  = '0;
            state_d = UNLOCKED;
          end
        end
        LOCKED: begin
          if (bad_w) begin
            good_d   = '0;
            state_d  = UNLOCKED;
            lost_set = 1'b1;
          end
        end
        default: begin
          good_d  = '0;
          state_d = UNLOCKED;
        end
      endcase
    end
    locked_d = (state_d == LOCKED);
    lost_d   = lost_set ? 1'b1 : (clear_lost ? 1'b0 : lost_q);
  end

  assign locked      = locked_q;
  assign lock_lost   = lost_q;
  assign active_cnt  = active_q;
  assign freq_dir    = dir_q;
  assign window_done = done_q;

endmodule
